pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (min 1).
REQ-002 Parameter LOCK_TIMEOUT, default 50000: cycles to wait for lock before retrying (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before system reset release.
REQ-004 Parameter MAX_RETRIES, default 3: retries after the first attempt before declaring failure.
REQ-005 clk  in  1  reference clock (50 MHz, same clock as PLL refclk); sole clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 locked_in  in  1  PLL locked flag; asynchronous to clk.
REQ-008 clear_fail  in  1  single-cycle request to leave FAIL and restart.
REQ-009 pll_rst  out  1  drives the PLL rst input, active-high.
REQ-010 sys_reset_n  out  1  system reset for PLL-clocked logic, active-low.
REQ-011 pll_ok  out  1  high only in RUN.
REQ-012 pll_fail  out  1  high only in FAIL.
REQ-013 retry_cnt  out  $clog2(MAX_RETRIES+1)  retries used in the current bring-up.
REQ-014 loss_cnt  out  8  lock-loss events seen in RUN.

Function
REQ-015 locked_in SHALL pass through a 2-flop synchronizer (locked_s) before any use; latency 2 cycles.
REQ-016 FSM states: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL; one shared cycle counter, cleared on every state change.
REQ-017 PLL_RST: pll_rst=1, sys_reset_n=0; after RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with locked_s=0 -> FAIL if retry_cnt==MAX_RETRIES, else retry_cnt+1 and -> PLL_RST.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK with a fresh timeout; STABLE_CYCLES consecutive locked_s=1 -> RUN.
REQ-020 Entering RUN: sys_reset_n and pll_ok go high on the transition edge; retry_cnt cleared.
REQ-021 RUN: locked_s=0 -> PLL_RST; sys_reset_n low on the next edge; loss_cnt+1, saturating at 255; retry_cnt cleared.
REQ-022 FAIL: pll_rst=1, sys_reset_n=0, pll_fail=1; clear_fail=1 -> PLL_RST with retry_cnt=0.
REQ-023 clear_fail SHALL be ignored outside FAIL.
REQ-024 All outputs SHALL be registered; no combinational path from locked_in or clear_fail to outputs.
REQ-025 A locked_s high pulse shorter than STABLE_CYCLES SHALL NOT release sys_reset_n.

Reset
REQ-026 While reset_n=0: state=PLL_RST, counter=0, synchronizer flops=0, pll_rst=1, sys_reset_n=0, pll_ok=0, pll_fail=0, retry_cnt=0, loss_cnt=0.
REQ-027 reset_n asserted in any state, including mid-count, SHALL restart the full sequence from PLL_RST after deassertion.

Configuration
REQ-028 Macro PLL_SUP_LOSS_CNT_EN: defined -> loss_cnt behaves per REQ-021; undefined -> loss_cnt is constant 0 and its counter register is not built.

Structure
REQ-029 Package pll_sup_pkg: FSM state enum and default timing constants.
REQ-030 The synchronizer SHALL be a sub-module named sync_2ff.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 locked_in rises 10 cycles after reset release and stays high -> pll_rst low at cycle 4; sys_reset_n and pll_ok high at cycle 20 (10+2 sync+8 stable); retry_cnt=0.
REQ-032 locked_in held low -> 3 attempts of 4+20 cycles each, retry_cnt 0,1,2; FAIL and pll_fail=1 after the third timeout; pll_rst stays 1.
REQ-033 In FAIL, pulse clear_fail -> PLL_RST next edge, retry_cnt=0; with locked_in=1 the sequence reaches RUN.
REQ-034 In RUN, drop locked_in for 1 cycle -> sys_reset_n low 3 edges later; loss_cnt=1; pll_rst pulses for 4 cycles; relock -> RUN again.
REQ-035 In STABLE, drop locked_in after 5 locked cycles -> back to WAIT_LOCK; sys_reset_n stays 0 throughout.
REQ-036 Force 256 lock losses -> loss_cnt saturates at 255; with PLL_SUP_LOSS_CNT_EN undefined, loss_cnt stays 0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and default timing for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  // The shared counter only ever counts up to (longest phase - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and system reset release, with retries.
// Build option: define PLL_SUP_LOSS_CNT_EN to build the lock-loss event counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               locked_in,
  input  logic                               clear_fail,
  output logic                               pll_rst,
  output logic                               sys_reset_n,
  output logic                               pll_ok,
  output logic                               pll_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         loss_cnt,
  output logic [2:0]                         state
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  pll_state_e    st;
  logic [CW-1:0] cnt;
  logic          locked_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (locked_in),
    .q       (locked_s)
  );

  assign state = st;

  // Outputs are updated on the same edge as the state change they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= ST_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      pll_ok      <= 1'b0;
      pll_fail    <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      case (st)
        ST_PLL_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            st      <= ST_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            st  <= ST_STABLE;
            cnt <= '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt == RW'(MAX_RETRIES)) begin
              st       <= ST_FAIL;
              pll_fail <= 1'b1;
            end else begin
              st        <= ST_PLL_RST;
              retry_cnt <= retry_cnt + RW'(1);
            end
          end
        end
        ST_STABLE: begin
          // Any dropout restarts qualification, so short lock pulses never release reset.
          if (!locked_s) begin
            st  <= ST_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            st          <= ST_RUN;
            cnt         <= '0;
            sys_reset_n <= 1'b1;
            pll_ok      <= 1'b1;
            retry_cnt   <= '0;
          end
        end
        ST_RUN: begin
          cnt <= '0;
          if (!locked_s) begin
            st          <= ST_PLL_RST;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            pll_ok      <= 1'b0;
            retry_cnt   <= '0;
          end
        end
        ST_FAIL: begin
          cnt <= '0;
          if (clear_fail) begin
            st        <= ST_PLL_RST;
            pll_fail  <= 1'b0;
            retry_cnt <= '0;
          end
        end
        default: begin
          st          <= ST_PLL_RST;
          cnt         <= '0;
          pll_rst     <= 1'b1;
          sys_reset_n <= 1'b0;
          pll_ok      <= 1'b0;
          pll_fail    <= 1'b0;
          retry_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else if (st == ST_RUN && !locked_s && loss_q != 8'hff) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int W = 16;

  logic       clk;
  logic       reset_n;
  logic       locked_in;
  logic       clear_fail;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       pll_ok;
  logic       pll_fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int tests_run;
  int tests_failed;
  int loss_model;
  int n;
  int bad;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .clear_fail  (clear_fail),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .pll_ok      (pll_ok),
    .pll_fail    (pll_fail),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks; inputs change and outputs are sampled on the falling edge
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    clear_fail = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_run(input int budget, output int cnt_out);
    cnt_out = 0;
    while (!pll_ok && cnt_out < budget) begin
      step(1);
      cnt_out++;
    end
  endtask

  // scoreboard
  task automatic push_exp(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_chk(input logic [W-1:0] obs);
    logic [W-1:0] e;
    string        t;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [W-1:0] loss_exp();
`ifdef PLL_SUP_LOSS_CNT_EN
    return W'(loss_model);
`else
    return '0;
`endif
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    loss_model   = 0;
    bad          = 0;
    locked_in    = 1'b0;
    clear_fail   = 1'b0;
    reset_n      = 1'b0;

    // reset values
    step(2);
    push_exp("rst_pll_rst", 1); push_exp("rst_sys_reset_n", 0);
    push_exp("rst_pll_ok", 0);  push_exp("rst_pll_fail", 0);
    push_exp("rst_retry", 0);   push_exp("rst_loss", 0);
    push_exp("rst_state", W'(ST_PLL_RST));
    pop_chk(W'(pll_rst)); pop_chk(W'(sys_reset_n)); pop_chk(W'(pll_ok));
    pop_chk(W'(pll_fail)); pop_chk(W'(retry_cnt)); pop_chk(W'(loss_cnt));
    pop_chk(W'(state));

    // normal bring-up: lock appears before edge 10, RUN on edge 20
    reset_n = 1'b1;
    push_exp("bring_pll_rst_e3", 1); step(3); pop_chk(W'(pll_rst));
    push_exp("bring_pll_rst_e4", 0); step(1); pop_chk(W'(pll_rst));
    step(5);
    locked_in = 1'b1;
    push_exp("bring_sys_e19", 0); step(10); pop_chk(W'(sys_reset_n));
    push_exp("bring_sys_e20", 1); push_exp("bring_ok_e20", 1);
    push_exp("bring_retry", 0);   push_exp("bring_state", W'(ST_RUN));
    step(1);
    pop_chk(W'(sys_reset_n)); pop_chk(W'(pll_ok)); pop_chk(W'(retry_cnt)); pop_chk(W'(state));

    // clear_fail has no effect in RUN
    clear_fail = 1'b1;
    push_exp("clr_in_run_state", W'(ST_RUN)); push_exp("clr_in_run_ok", 1);
    step(1);
    clear_fail = 1'b0;
    pop_chk(W'(state)); pop_chk(W'(pll_ok));

    // one-cycle lock loss in RUN
    locked_in = 1'b0;
    step(1);
    locked_in = 1'b1;
    push_exp("loss_sys_e2", 1); step(1); pop_chk(W'(sys_reset_n));
    loss_model++;
    push_exp("loss_sys_e3", 0); push_exp("loss_pll_rst_e3", 1); push_exp("loss_cnt_1", loss_exp());
    step(1);
    pop_chk(W'(sys_reset_n)); pop_chk(W'(pll_rst)); pop_chk(W'(loss_cnt));
    push_exp("loss_pll_rst_e6", 1); step(3); pop_chk(W'(pll_rst));
    push_exp("loss_pll_rst_e7", 0); step(1); pop_chk(W'(pll_rst));
    push_exp("loss_relock_cycles", 9); wait_run(40, n); pop_chk(W'(n));

    // lock drops after 5 cycles in STABLE
    locked_in = 1'b1;
    apply_reset();
    loss_model = 0;
    step(8);
    locked_in = 1'b0;
    push_exp("stable_state_e10", W'(ST_STABLE)); step(2); pop_chk(W'(state));
    push_exp("stable_state_e11", W'(ST_WAIT_LOCK)); push_exp("stable_sys_e11", 0);
    step(1);
    pop_chk(W'(state)); pop_chk(W'(sys_reset_n));
    locked_in = 1'b1;
    push_exp("stable_requal_cycles", 11); wait_run(40, n); pop_chk(W'(n));

    // no lock: three timed-out attempts then FAIL
    locked_in = 1'b0;
    apply_reset();
    push_exp("to_retry_e23", 0); push_exp("to_pll_rst_e23", 0);
    step(23);
    pop_chk(W'(retry_cnt)); pop_chk(W'(pll_rst));
    push_exp("to_retry_e24", 1); push_exp("to_pll_rst_e24", 1);
    step(1);
    pop_chk(W'(retry_cnt)); pop_chk(W'(pll_rst));
    push_exp("to_retry_e48", 2); step(24); pop_chk(W'(retry_cnt));
    push_exp("to_fail_e71", 0); step(23); pop_chk(W'(pll_fail));
    push_exp("to_fail_e72", 1); push_exp("to_pll_rst_e72", 1);
    push_exp("to_state_e72", W'(ST_FAIL)); push_exp("to_sys_e72", 0);
    step(1);
    pop_chk(W'(pll_fail)); pop_chk(W'(pll_rst)); pop_chk(W'(state)); pop_chk(W'(sys_reset_n));
    push_exp("fail_hold_state", W'(ST_FAIL)); step(5); pop_chk(W'(state));

    // leave FAIL with clear_fail, lock present
    locked_in  = 1'b1;
    clear_fail = 1'b1;
    step(1);
    clear_fail = 1'b0;
    push_exp("clr_state", W'(ST_PLL_RST)); push_exp("clr_retry", 0);
    push_exp("clr_fail", 0);               push_exp("clr_pll_rst", 1);
    pop_chk(W'(state)); pop_chk(W'(retry_cnt)); pop_chk(W'(pll_fail)); pop_chk(W'(pll_rst));
    push_exp("clr_to_run_cycles", 13); wait_run(40, n); pop_chk(W'(n));

    // reset asserted mid-count restarts the full sequence
    locked_in = 1'b0;
    apply_reset();
    push_exp("mid_retry_e30", 1); step(30); pop_chk(W'(retry_cnt));
    reset_n = 1'b0;
    #1;
    push_exp("mid_state", W'(ST_PLL_RST)); push_exp("mid_retry", 0); push_exp("mid_pll_rst", 1);
    pop_chk(W'(state)); pop_chk(W'(retry_cnt)); pop_chk(W'(pll_rst));
    step(2);
    reset_n = 1'b1;
    push_exp("mid_pll_rst_e3", 1); step(3); pop_chk(W'(pll_rst));
    push_exp("mid_pll_rst_e4", 0); step(1); pop_chk(W'(pll_rst));

    // 256 lock losses: counter saturates (or stays 0 when not built)
    locked_in = 1'b1;
    apply_reset();
    loss_model = 0;
    push_exp("sat_first_run_cycles", 13); wait_run(40, n); pop_chk(W'(n));
    for (int i = 0; i < 256; i++) begin
      locked_in = 1'b0;
      step(1);
      locked_in = 1'b1;
      step(2);
      if (pll_ok) bad++;
      wait_run(40, n);
      if (n != 13) bad++;
      if (loss_model < 255) loss_model++;
    end
    push_exp("sat_relock_errors", 0); pop_chk(W'(bad));
    push_exp("sat_loss_cnt", loss_exp()); pop_chk(W'(loss_cnt));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
